// File: rtl/mem_if_pkg.sv
// Shared types and constants for the data-memory responder.
// State encoding, default base address and bus widths.
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h1001_0000;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

endpackage

// File: rtl/mem_addr_decode.sv
// Byte address to word index decode with range and alignment check.
// Offset is formed in ADDR_W+1 bits so addresses below the base borrow out.
module mem_addr_decode
  import mem_if_pkg::*;
#(
  parameter int                WORDS     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int                IDX_W     = $clog2(WORDS)
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic              err_o
);

  localparam logic [ADDR_W-3:0] LIMIT = (ADDR_W-2)'(WORDS);

  logic [ADDR_W:0]   off;
  logic [ADDR_W-3:0] word;

  assign off  = {1'b0, addr_i} - {1'b0, BASE_ADDR};
  assign word = off[ADDR_W-1:2];

  assign idx_o = word[IDX_W-1:0];

  // base is word aligned, so the low offset bits equal the low address bits
  assign err_o = (|off[1:0]) | off[ADDR_W] | (word >= LIMIT);

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one outstanding load/store, fixed latency,
// valid/ready response channel, registered outputs.
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int                WORDS     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int                LATENCY   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int IDX_W = $clog2(WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              req_ready_q;
  logic              busy_q;

  logic [DATA_W-1:0] mem_q [WORDS];

  logic              idle;
  logic              access;
  logic              cur_write;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [IDX_W-1:0]  dec_idx;
  logic              dec_err;
  logic              we;
  logic [DATA_W-1:0] rdata_d;

  // with LATENCY==1 the access happens on the accept edge, so
  // the live request fields are used while idle
  assign idle      = (state_q == IDLE);
  assign cur_write = idle ? req_write : write_q;
  assign cur_addr  = idle ? req_addr  : addr_q;
  assign cur_wdata = idle ? req_wdata : wdata_q;

  assign access = (idle & req_valid & (LATENCY == 1))
                | ((state_q == WAIT) & (cnt_q == '0));

  mem_addr_decode #(
    .WORDS     (WORDS),
    .BASE_ADDR (BASE_ADDR),
    .IDX_W     (IDX_W)
  ) u_dec (
    .addr_i (cur_addr),
    .idx_o  (dec_idx),
    .err_o  (dec_err)
  );

  assign we      = reset & access & cur_write & ~dec_err;
  assign rdata_d = (cur_write | dec_err) ? '0 : mem_q[dec_idx];

  // storage: no reset, written once per good store
  always_ff @(posedge clk) begin
    if (we) mem_q[dec_idx] <= cur_wdata;
  end

  // request/response sequencing with registered handshake outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q     <= req_write;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            cnt_q       <= CNT_INIT;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (LATENCY == 1) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              rdata_q      <= rdata_d;
              err_q        <= dec_err;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            rdata_q      <= rdata_d;
            err_q        <= dec_err;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: LATENCY=2 and LATENCY=1 instances,
// table-driven transactions with a response scoreboard.
module tb_data_mem_responder;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] erd;
    logic        eerr;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_n;

  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err, busy;
  logic [31:0] resp_rdata;

  logic        req_valid1, req_ready1, req_write1;
  logic [31:0] req_addr1, req_wdata1;
  logic        resp_valid1, resp_ready1, resp_err1, busy1;
  logic [31:0] resp_rdata1;

  exp_t sbq[$];
  vec_t tv[$];
  vec_t tv1[$];
  int   ncmp = 0;
  int   nbad = 0;

  data_mem_responder #(
    .WORDS(1024), .BASE_ADDR(32'h1001_0000), .LATENCY(2)
  ) u0 (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy)
  );

  data_mem_responder #(
    .WORDS(1024), .BASE_ADDR(32'h1001_0000), .LATENCY(1)
  ) u1 (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid1), .req_ready(req_ready1),
    .req_write(req_write1), .req_addr(req_addr1),
    .req_wdata(req_wdata1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1),
    .resp_rdata(resp_rdata1), .resp_err(resp_err1),
    .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    ncmp++;
    if (act !== want) begin
      nbad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic pop_chk(input string nm, input logic [31:0] rd,
                         input logic err);
    exp_t e;
    if (sbq.size() == 0) begin
      ncmp++;
      nbad++;
      $display("FAIL %s.sb: got empty want entry", nm);
    end else begin
      e = sbq.pop_front();
      chk($sformatf("%s.rdata", nm), rd, e.rd);
      chk($sformatf("%s.err", nm), 32'(err), 32'(e.err));
    end
  endtask

  // call just after the accept edge; k = edges until resp_valid seen
  task automatic wait_resp(output int k);
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      if (resp_valid) break;
      @(posedge clk);
      k++;
    end
  endtask

  task automatic xact(input vec_t v, input string nm);
    int k;
    @(negedge clk);
    chk($sformatf("%s.ready", nm), 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = v.wr;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    sbq.push_back('{rd: v.erd, err: v.eerr});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = ~v.wr;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = ~v.wdata;
    wait_resp(k);
    chk($sformatf("%s.lat", nm), 32'(k), 32'd2);
    pop_chk(nm, resp_rdata, resp_err);
    @(posedge clk);
    #1;
    chk($sformatf("%s.idle", nm), 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int k;
    logic [31:0] held;
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    resp_ready  = 1'b1;
    req_valid1  = 1'b0;
    req_write1  = 1'b0;
    req_addr1   = '0;
    req_wdata1  = '0;
    resp_ready1 = 1'b1;

    tv.push_back('{1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 32'h0, 1'b0});
    tv.push_back('{1'b0, 32'h1001_0008, 32'h0, 32'hDEAD_BEEF, 1'b0});
    tv.push_back('{1'b1, 32'h1001_000C, 32'h1234_5678, 32'h0, 1'b0});
    tv.push_back('{1'b0, 32'h1001_000C, 32'h0, 32'h1234_5678, 1'b0});
    tv.push_back('{1'b1, 32'h1001_0004, 32'hCAFE_F00D, 32'h0, 1'b0});
    tv.push_back('{1'b1, 32'h1001_0006, 32'h5555_5555, 32'h0, 1'b1});
    tv.push_back('{1'b0, 32'h1001_0004, 32'h0, 32'hCAFE_F00D, 1'b0});
    tv.push_back('{1'b0, 32'h0FFF_FFFC, 32'h0, 32'h0, 1'b1});
    tv.push_back('{1'b0, 32'h1001_1000, 32'h0, 32'h0, 1'b1});
    tv.push_back('{1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1});
    tv.push_back('{1'b1, 32'h1001_1000, 32'h7777_7777, 32'h0, 1'b1});
    tv.push_back('{1'b1, 32'h1001_0FFC, 32'hA5A5_5A5A, 32'h0, 1'b0});
    tv.push_back('{1'b0, 32'h1001_0FFC, 32'h0, 32'hA5A5_5A5A, 1'b0});
    tv.push_back('{1'b1, 32'h1001_0010, 32'h0000_0001, 32'h0, 1'b0});

    tv1.push_back('{1'b1, 32'h1001_0000, 32'h1111_1111, 32'h0, 1'b0});
    tv1.push_back('{1'b1, 32'h1001_0004, 32'h2222_2222, 32'h0, 1'b0});
    tv1.push_back('{1'b0, 32'h1001_0000, 32'h0, 32'h1111_1111, 1'b0});
    tv1.push_back('{1'b0, 32'h1001_0004, 32'h0, 32'h2222_2222, 1'b0});
    tv1.push_back('{1'b0, 32'h1001_0006, 32'h0, 32'h0, 1'b1});
    tv1.push_back('{1'b0, 32'h1001_0000, 32'h0, 32'h1111_1111, 1'b0});

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ready", 32'(req_ready), 32'd1);
    chk("rst.valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post.ready", 32'(req_ready), 32'd1);
    chk("post.valid", 32'(resp_valid), 32'd0);
    chk("post.busy", 32'(busy), 32'd0);
    chk("post.rdata", resp_rdata, 32'h0);
    chk("post.err", 32'(resp_err), 32'd0);

    foreach (tv[i]) xact(tv[i], $sformatf("v%0d", i));

    // response held while a new request is offered
    resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h1001_0008;
    sbq.push_back('{rd: 32'hDEAD_BEEF, err: 1'b0});
    @(posedge clk);
    #1;
    req_addr = 32'h1001_000C;
    wait_resp(k);
    chk("hold.lat", 32'(k), 32'd2);
    held = resp_rdata;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("hold%0d.valid", c), 32'(resp_valid), 32'd1);
      chk($sformatf("hold%0d.rdata", c), resp_rdata, 32'hDEAD_BEEF);
      chk($sformatf("hold%0d.ready", c), 32'(req_ready), 32'd0);
    end
    pop_chk("hold", held, resp_err);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rel.ready", 32'(req_ready), 32'd1);
    chk("rel.valid", 32'(resp_valid), 32'd0);
    sbq.push_back('{rd: 32'h1234_5678, err: 1'b0});
    @(posedge clk);
    #1;
    chk("next.busy", 32'(busy), 32'd1);
    req_valid = 1'b0;
    wait_resp(k);
    chk("next.lat", 32'(k), 32'd2);
    pop_chk("next", resp_rdata, resp_err);
    @(posedge clk);

    // reset during WAIT of a store
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h1001_0010;
    req_wdata = 32'h0BAD_0BAD;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("wait.busy", 32'(busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst.ready", 32'(req_ready), 32'd1);
    chk("arst.valid", 32'(resp_valid), 32'd0);
    chk("arst.busy", 32'(busy), 32'd0);
    chk("arst.rdata", resp_rdata, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    xact('{1'b0, 32'h1001_0010, 32'h0, 32'h0000_0001, 1'b0}, "afterrst");

    // LATENCY=1 back-to-back, req_valid held high
    @(negedge clk);
    req_valid1 = 1'b1;
    foreach (tv1[i]) begin
      chk($sformatf("b%0d.ready", i), 32'(req_ready1), 32'd1);
      chk($sformatf("b%0d.idle", i), 32'(resp_valid1), 32'd0);
      req_write1 = tv1[i].wr;
      req_addr1  = tv1[i].addr;
      req_wdata1 = tv1[i].wdata;
      sbq.push_back('{rd: tv1[i].erd, err: tv1[i].eerr});
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("b%0d.valid", i), 32'(resp_valid1), 32'd1);
      chk($sformatf("b%0d.nready", i), 32'(req_ready1), 32'd0);
      pop_chk($sformatf("b%0d", i), resp_rdata1, resp_err1);
      @(posedge clk);
      @(negedge clk);
    end
    req_valid1 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
